// File: rtl/spi_pkg.sv
// spi_pkg: command codes and FSM state encoding shared by the SPI memory controller and its bench
package spi_pkg;
  localparam logic [1:0] CMD_WR_ADDR = 2'b00;
  localparam logic [1:0] CMD_WR_DATA = 2'b01;
  localparam logic [1:0] CMD_RD_ADDR = 2'b10;
  localparam logic [1:0] CMD_RD_DATA = 2'b11;
  typedef enum logic [1:0] {
    IDLE    = 2'b00,
    WRITE   = 2'b01,
    RD_REQ  = 2'b10,
    RD_WAIT = 2'b11
  } state_t;
endpackage

// File: rtl/spi_mem_ctrl.sv
// spi_mem_ctrl: decodes 10-bit SPI frames (rx_data/rx_valid) into RAM writes/reads (mem_*), returns read data on tx_data/tx_valid, flags busy and err
module spi_mem_ctrl
  import spi_pkg::*;
#(
  parameter int ADDR_SIZE = 8,
  parameter int MEM_DEPTH = 256
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [9:0]           rx_data,
  input  logic                 rx_valid,
  output logic [7:0]           tx_data,
  output logic                 tx_valid,
  output logic [ADDR_SIZE-1:0] mem_addr,
  output logic                 mem_we,
  output logic                 mem_re,
  output logic [7:0]           mem_wdata,
  input  logic [7:0]           mem_rdata,
  output logic                 busy,
  output logic                 err
);
  localparam logic [ADDR_SIZE-1:0] LAST = ADDR_SIZE'(MEM_DEPTH - 1);
  state_t               state;
  logic [ADDR_SIZE-1:0] wr_addr, rd_addr, last_addr;
  logic                 rd_addr_ok;
  logic [7:0]           wdata_q;
  logic [1:0]           cmd;
  logic [7:0]           pl;
  always_comb begin
    cmd       = rx_data[9:8];
    pl        = rx_data[7:0];
    busy      = state != IDLE;
    mem_we    = state == WRITE;
    mem_re    = state == RD_REQ;
    mem_addr  = mem_we ? wr_addr : mem_re ? rd_addr : last_addr;
    mem_wdata = wdata_q;
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      wr_addr    <= '0;
      rd_addr    <= '0;
      last_addr  <= '0;
      rd_addr_ok <= 1'b0;
      wdata_q    <= '0;
      tx_data    <= '0;
      tx_valid   <= 1'b0;
      err        <= 1'b0;
    end else begin
      tx_valid <= 1'b0;
      err      <= rx_valid && (state != IDLE || (cmd == CMD_RD_DATA && !rd_addr_ok));
      case (state)
        IDLE: if (rx_valid) begin
          if (cmd == CMD_WR_ADDR) wr_addr <= pl[ADDR_SIZE-1:0];
          if (cmd == CMD_RD_ADDR) begin
            rd_addr    <= pl[ADDR_SIZE-1:0];
            rd_addr_ok <= 1'b1;
          end
          if (cmd == CMD_WR_DATA) begin
            wdata_q <= pl;
            state   <= WRITE;
          end
          if (cmd == CMD_RD_DATA && rd_addr_ok) state <= RD_REQ;
        end
        WRITE: begin
          last_addr <= wr_addr;
          wr_addr   <= wr_addr == LAST ? '0 : wr_addr + 1'b1;
          state     <= IDLE;
        end
        RD_REQ: begin
          last_addr <= rd_addr;
          rd_addr   <= rd_addr == LAST ? '0 : rd_addr + 1'b1;
          state     <= RD_WAIT;
        end
        RD_WAIT: begin
          tx_data  <= mem_rdata;
          tx_valid <= 1'b1;
          state    <= IDLE;
        end
      endcase
    end
  end
endmodule

// File: tb/tb_spi_mem_ctrl.sv
// tb_spi_mem_ctrl: directed and randomized checks of spi_mem_ctrl against a frame-level reference model
module tb_spi_mem_ctrl;
  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic [9:0] rx_data = '0;
  logic       rx_valid = 1'b0;
  logic [7:0] tx_data;
  logic       tx_valid;
  logic [7:0] mem_addr;
  logic       mem_we;
  logic       mem_re;
  logic [7:0] mem_wdata;
  logic [7:0] mem_rdata;
  logic       busy;
  logic       err;
  int total = 0;
  int bad = 0;
  bit [7:0] ram [256];
  bit [7:0] m_mem [256];
  logic [7:0] m_wr, m_rd;
  bit m_ok;

  spi_mem_ctrl #(.ADDR_SIZE(8), .MEM_DEPTH(256)) dut (
    .clk(clk), .rst(rst), .rx_data(rx_data), .rx_valid(rx_valid),
    .tx_data(tx_data), .tx_valid(tx_valid), .mem_addr(mem_addr),
    .mem_we(mem_we), .mem_re(mem_re), .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata), .busy(busy), .err(err)
  );

  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (mem_we) ram[mem_addr] <= mem_wdata;
    if (mem_re) mem_rdata <= ram[mem_addr];
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_idle();
    int n = 0;
    while (busy === 1'b1 && n < 10) begin
      tick();
      n++;
    end
    if (busy !== 1'b0) begin
      total++;
      bad++;
      $display("FAIL idle_timeout: busy=%b want 0", busy);
    end
  endtask

  task automatic send(input logic [9:0] f);
    wait_idle();
    rx_data  = f;
    rx_valid = 1'b1;
    tick();
    rx_valid = 1'b0;
  endtask

  task automatic model_reset();
    m_wr = 8'h00;
    m_rd = 8'h00;
    m_ok = 1'b0;
  endtask

  task automatic test_reset();
    rst      = 1'b1;
    rx_data  = 10'h1FF;
    rx_valid = 1'b1;
    tick();
    tick();
    rst      = 1'b0;
    rx_valid = 1'b0;
    model_reset();
    total++;
    if ({busy, tx_valid, err, mem_we, mem_re} !== 5'b0) begin
      bad++;
      $display("FAIL reset_flags: busy=%b tx_valid=%b err=%b we=%b re=%b want all 0", busy, tx_valid, err, mem_we, mem_re);
    end
    total++;
    if (mem_addr !== 8'h00 || tx_data !== 8'h00) begin
      bad++;
      $display("FAIL reset_regs: mem_addr=%h tx_data=%h want 00 00", mem_addr, tx_data);
    end
    tick();
    total++;
    if (mem_we !== 1'b0 || busy !== 1'b0) begin
      bad++;
      $display("FAIL reset_frame_ignored: we=%b busy=%b want 0 0", mem_we, busy);
    end
  endtask

  task automatic test_illegal();
    send(10'h3AA);
    total++;
    if (err !== 1'b1 || mem_re !== 1'b0 || busy !== 1'b0) begin
      bad++;
      $display("FAIL rd_before_addr: err=%b re=%b busy=%b want 1 0 0", err, mem_re, busy);
    end
    tick();
    total++;
    if (err !== 1'b0) begin
      bad++;
      $display("FAIL err_pulse_width: err=%b want 0", err);
    end
  endtask

  task automatic test_write();
    send(10'h0A5);
    send(10'h13C);
    total++;
    if (mem_we !== 1'b1 || mem_addr !== 8'hA5 || mem_wdata !== 8'h3C) begin
      bad++;
      $display("FAIL write_strobe: we=%b addr=%h wdata=%h want 1 a5 3c", mem_we, mem_addr, mem_wdata);
    end
    m_mem[8'hA5] = 8'h3C;
    tick();
    total++;
    if (mem_we !== 1'b0 || busy !== 1'b0 || mem_addr !== 8'hA5) begin
      bad++;
      $display("FAIL write_end: we=%b busy=%b addr=%h want 0 0 a5", mem_we, busy, mem_addr);
    end
    send(10'h155);
    total++;
    if (mem_we !== 1'b1 || mem_addr !== 8'hA6 || mem_wdata !== 8'h55) begin
      bad++;
      $display("FAIL write_incr: we=%b addr=%h wdata=%h want 1 a6 55", mem_we, mem_addr, mem_wdata);
    end
    m_mem[8'hA6] = 8'h55;
    m_wr = 8'hA7;
  endtask

  task automatic test_read();
    int hits = 0;
    send(10'h2A5);
    send(10'h300 | 10'($urandom_range(0, 255)));
    total++;
    if (mem_re !== 1'b1 || mem_addr !== 8'hA5 || tx_valid !== 1'b0) begin
      bad++;
      $display("FAIL read_req: re=%b addr=%h tx_valid=%b want 1 a5 0", mem_re, mem_addr, tx_valid);
    end
    tick();
    tick();
    total++;
    if (tx_valid !== 1'b1 || tx_data !== 8'h3C) begin
      bad++;
      $display("FAIL read_data: tx_valid=%b tx_data=%h want 1 3c", tx_valid, tx_data);
    end
    for (int i = 0; i < 3; i++) begin
      tick();
      if (tx_valid === 1'b1) hits++;
    end
    total++;
    if (hits != 0 || tx_data !== 8'h3C) begin
      bad++;
      $display("FAIL read_pulse: extra_tx_cycles=%0d tx_data=%h want 0 3c", hits, tx_data);
    end
    m_rd = 8'hA6;
    m_ok = 1'b1;
  endtask

  task automatic test_wrap();
    send(10'h0FF);
    send(10'h111);
    total++;
    if (mem_we !== 1'b1 || mem_addr !== 8'hFF || mem_wdata !== 8'h11) begin
      bad++;
      $display("FAIL wrap_write_ff: we=%b addr=%h wdata=%h want 1 ff 11", mem_we, mem_addr, mem_wdata);
    end
    send(10'h122);
    total++;
    if (mem_we !== 1'b1 || mem_addr !== 8'h00 || mem_wdata !== 8'h22) begin
      bad++;
      $display("FAIL wrap_write_00: we=%b addr=%h wdata=%h want 1 00 22", mem_we, mem_addr, mem_wdata);
    end
    m_mem[8'hFF] = 8'h11;
    m_mem[8'h00] = 8'h22;
    m_wr = 8'h01;
    send(10'h2FF);
    send(10'h300);
    tick();
    tick();
    total++;
    if (tx_valid !== 1'b1 || tx_data !== 8'h11) begin
      bad++;
      $display("FAIL wrap_read_ff: tx_valid=%b tx_data=%h want 1 11", tx_valid, tx_data);
    end
    send(10'h3FF);
    total++;
    if (mem_re !== 1'b1 || mem_addr !== 8'h00) begin
      bad++;
      $display("FAIL wrap_read_addr: re=%b addr=%h want 1 00", mem_re, mem_addr);
    end
    tick();
    tick();
    total++;
    if (tx_valid !== 1'b1 || tx_data !== 8'h22) begin
      bad++;
      $display("FAIL wrap_read_00: tx_valid=%b tx_data=%h want 1 22", tx_valid, tx_data);
    end
    m_rd = 8'h01;
    m_ok = 1'b1;
  endtask

  task automatic test_overrun();
    logic [7:0] want;
    want = m_mem[m_rd];
    send(10'h300);
    tick();
    rx_data  = 10'h1EE;
    rx_valid = 1'b1;
    tick();
    rx_valid = 1'b0;
    m_rd = m_rd + 8'h01;
    total++;
    if (tx_valid !== 1'b1 || tx_data !== want || err !== 1'b1) begin
      bad++;
      $display("FAIL overrun: tx_valid=%b tx_data=%h err=%b want 1 %h 1", tx_valid, tx_data, err, want);
    end
    total++;
    if (mem_we !== 1'b0 || busy !== 1'b0) begin
      bad++;
      $display("FAIL overrun_dropped: we=%b busy=%b want 0 0", mem_we, busy);
    end
  endtask

  task automatic test_reset_mid_read();
    int hits = 0;
    send(10'h300);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    model_reset();
    for (int i = 0; i < 5; i++) begin
      if (tx_valid === 1'b1 || err === 1'b1) hits++;
      tick();
    end
    total++;
    if (hits != 0 || busy !== 1'b0 || mem_addr !== 8'h00) begin
      bad++;
      $display("FAIL reset_mid_read: tx_or_err_cycles=%0d busy=%b addr=%h want 0 0 00", hits, busy, mem_addr);
    end
    send(10'h300);
    total++;
    if (err !== 1'b1 || mem_re !== 1'b0) begin
      bad++;
      $display("FAIL reset_clears_ok: err=%b re=%b want 1 0", err, mem_re);
    end
    send(10'h177);
    total++;
    if (mem_we !== 1'b1 || mem_addr !== 8'h00) begin
      bad++;
      $display("FAIL reset_clears_wr: we=%b addr=%h want 1 00", mem_we, mem_addr);
    end
    m_mem[8'h00] = 8'h77;
    m_wr = 8'h01;
  endtask

  task automatic test_random();
    for (int i = 0; i < 60; i++) begin
      logic [1:0] c;
      logic [7:0] p;
      logic [7:0] want;
      c = 2'($urandom_range(0, 3));
      p = (c == 2'b00 || c == 2'b10) ? 8'($urandom_range(0, 15)) : 8'($urandom);
      if (c == 2'b00) begin
        m_wr = p;
        send({c, p});
        total++;
        if (busy !== 1'b0 || err !== 1'b0) begin
          bad++;
          $display("FAIL rnd_wr_addr[%0d]: busy=%b err=%b want 0 0", i, busy, err);
        end
      end else if (c == 2'b01) begin
        send({c, p});
        total++;
        if (mem_we !== 1'b1 || mem_addr !== m_wr || mem_wdata !== p) begin
          bad++;
          $display("FAIL rnd_write[%0d]: we=%b addr=%h wdata=%h want 1 %h %h", i, mem_we, mem_addr, mem_wdata, m_wr, p);
        end
        m_mem[m_wr] = p;
        m_wr = m_wr + 8'h01;
      end else if (c == 2'b10) begin
        m_rd = p;
        m_ok = 1'b1;
        send({c, p});
        total++;
        if (busy !== 1'b0 || err !== 1'b0) begin
          bad++;
          $display("FAIL rnd_rd_addr[%0d]: busy=%b err=%b want 0 0", i, busy, err);
        end
      end else if (!m_ok) begin
        send({c, p});
        total++;
        if (err !== 1'b1 || mem_re !== 1'b0) begin
          bad++;
          $display("FAIL rnd_rd_illegal[%0d]: err=%b re=%b want 1 0", i, err, mem_re);
        end
      end else begin
        want = m_mem[m_rd];
        send({c, p});
        tick();
        tick();
        total++;
        if (tx_valid !== 1'b1 || tx_data !== want) begin
          bad++;
          $display("FAIL rnd_read[%0d]: tx_valid=%b tx_data=%h want 1 %h", i, tx_valid, tx_data, want);
        end
        m_rd = m_rd + 8'h01;
      end
    end
  endtask

  initial begin
    tick();
    test_reset();
    test_illegal();
    test_write();
    test_read();
    test_wrap();
    test_overrun();
    test_reset_mid_read();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/spi_mem_ctrl.md
Name: spi_mem_ctrl

Overview:
- Command sequencer between the SPI slave receive/transmit interface and a single-port synchronous RAM.
- Decodes each 10-bit frame from the SPI slave as a 2-bit command plus an 8-bit payload.
- Owns the write and read address registers and drives the RAM port.
- Returns read data to the SPI slave through the tx_valid/tx_data handshake for shifting out on MISO.

Parameters:
ADDR_SIZE, 8, RAM address width; legal range 1..8; only payload bits [ADDR_SIZE-1:0] are used as the address.
MEM_DEPTH, 256, RAM depth; must equal 2**ADDR_SIZE.

Ports:
clk  input  1  system clock; all logic on rising edge
rst  input  1  synchronous, active-high reset
rx_data  input  10  frame from SPI slave; [9:8] command, [7:0] payload
rx_valid  input  1  one-cycle pulse; rx_data valid in the same cycle
tx_data  output  8  read data to SPI slave; registered
tx_valid  output  1  one-cycle pulse; tx_data valid in the same cycle
mem_addr  output  ADDR_SIZE  RAM address
mem_we  output  1  RAM write enable
mem_re  output  1  RAM read enable; RAM returns mem_rdata on the next rising edge
mem_wdata  output  8  RAM write data
mem_rdata  input  8  RAM read data, one cycle after the mem_re cycle
busy  output  1  high whenever the FSM is not in IDLE
err  output  1  one-cycle pulse on a dropped or illegal command

Behaviour:
- Reset:
  - On a rising edge with rst=1: state=IDLE; wr_addr=0; rd_addr=0; rd_addr_ok=0; tx_data=0; tx_valid=0; err=0.
  - From the following cycle: mem_we=0, mem_re=0, mem_addr=0, busy=0.
  - Reset mid-operation aborts with no write, no tx_valid and no err.
- Command encoding (cmd=rx_data[9:8], pl=rx_data[7:0]), sampled only in IDLE when rx_valid=1:
  - 00 WR_ADDR: wr_addr<=pl; state stays IDLE.
  - 01 WR_DATA: latch pl into wdata_q; go to WRITE.
  - 10 RD_ADDR: rd_addr<=pl; rd_addr_ok<=1; state stays IDLE.
  - 11 RD_DATA: if rd_addr_ok=1, go to RD_REQ; else pulse err next cycle and stay IDLE. The payload is a don't-care.
- FSM states: IDLE, WRITE, RD_REQ, RD_WAIT. mem_* outputs are decoded from the state.
  - WRITE (1 cycle): mem_we=1, mem_addr=wr_addr, mem_wdata=wdata_q; at the edge, wr_addr<=wr_addr+1 (wraps MEM_DEPTH-1 -> 0); go to IDLE.
  - RD_REQ (1 cycle): mem_re=1, mem_addr=rd_addr; at the edge, rd_addr<=rd_addr+1 (wraps); go to RD_WAIT.
  - RD_WAIT (1 cycle): mem_rdata is valid; at the edge, tx_data<=mem_rdata, tx_valid<=1; go to IDLE.
  - Outside WRITE and RD_REQ: mem_we=0, mem_re=0, mem_addr holds its last value.
- Latency:
  - WR_DATA: rx_valid at cycle N gives the write strobe at N+1.
  - RD_DATA: rx_valid at cycle N gives mem_re at N+1 and tx_valid at N+3.
  - tx_valid falls at N+4; tx_data holds until the next read completes.
- rx_valid while busy=1: frame dropped, no state change, err pulses the next cycle.
- rx_valid together with rst=1: reset wins; the frame is ignored.
- rd_addr_ok stays 1 until reset; consecutive RD_DATA frames stream sequential addresses.
- Back-to-back WR_DATA frames write consecutive addresses, each one cycle after its rx_valid.
- Every 00 or 10 frame updates its address register unconditionally.

Decomposition:
- Shared package spi_pkg holds:
  - command constants CMD_WR_ADDR=2'b00, CMD_WR_DATA=2'b01, CMD_RD_ADDR=2'b10, CMD_RD_DATA=2'b11;
  - the FSM state encoding (IDLE=2'b00, WRITE=2'b01, RD_REQ=2'b10, RD_WAIT=2'b11).
- No sub-module: the address registers, FSM and output decode live in one module.
- The bench pairs it with a behavioural single-port RAM model (spi_ram, one-cycle read latency).

Test Plan:
- Reset: assert rst for 2 cycles, then release -> busy=0, tx_valid=0, err=0, mem_we=0, mem_re=0, wr_addr=0, rd_addr_ok=0.
- Write: 0x0A5 (addr 0xA5), then 0x13C -> one cycle after the second rx_valid: mem_we=1, mem_addr=0xA5, mem_wdata=0x3C; wr_addr becomes 0xA6.
- Read: 0x2A5, then 0x3xx -> mem_re=1 at N+1 with mem_addr=0xA5; tx_valid=1 at N+3 with tx_data=0x3C, for exactly 1 cycle.
- Wrap: WR_ADDR 0xFF, then WR_DATA 0x11 and WR_DATA 0x22 -> RAM[0xFF]=0x11 and RAM[0x00]=0x22; read them back with RD_ADDR 0xFF plus two RD_DATA -> tx_data 0x11 then 0x22.
- Illegal and overrun:
  - RD_DATA right after reset -> err pulse, no mem_re.
  - rx_valid during RD_WAIT -> frame dropped, err pulse, tx_valid still delivered.
- Reset mid-read: rst=1 in the RD_REQ cycle -> no tx_valid ever, state IDLE, rd_addr=0, rd_addr_ok=0.
